// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - instruction fetch PC generator with stall buffering and branch redirect.
// Optional misaligned-redirect checking is enabled by defining PC_ALIGN_CHK_EN.
module pc_gen #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        br_e,
  input  logic [63:0] br_addr,
  output logic        inst_req,
  output logic [63:0] inst_addr,
  input  logic        inst_ack,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic        flush,
  output logic        misalign_err
);

  typedef enum logic [2:0] {BOOT, RUN, WAIT, FULL, KILL} state_t;

  state_t      state, state_nx;
  logic [63:0] pc, pc_nx, buf_pc, buf_pc_nx, tgt_pc, tgt_pc_nx, if_pc_nx;
  logic        if_valid_nx;
  logic        br_take;
  logic [63:0] br_tgt;

`ifdef PC_ALIGN_CHK_EN
  logic misalign_set;
  assign br_take      = br_e & (br_addr[1:0] == 2'b00);
  assign br_tgt       = br_addr;
  assign misalign_set = br_e & (br_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      misalign_err <= 1'b0;
    else if (misalign_set)
      misalign_err <= 1'b1;
  end
`else
  logic unused_br_lsb;
  assign br_take       = br_e;
  assign br_tgt        = {br_addr[63:2], 2'b00};
  assign unused_br_lsb = ^br_addr[1:0];
  assign misalign_err  = 1'b0;
`endif

  // Gated by resetn so flush stays low while the block is held in reset.
  assign flush = br_take & resetn;

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    buf_pc_nx   = buf_pc;
    tgt_pc_nx   = tgt_pc;
    if_pc_nx    = if_pc;
    if_valid_nx = stall ? if_valid : 1'b0;
    inst_addr   = pc;
    case (state)
      RUN:       inst_req = ~stall;
      WAIT, KILL: inst_req = 1'b1;
      default:   inst_req = 1'b0;
    endcase

    if (br_take) begin
      if_valid_nx = 1'b0;
      // An unacked request must stay on the bus, so park the target until it drains.
      if (inst_req && !inst_ack) begin
        tgt_pc_nx = br_tgt;
        state_nx  = KILL;
      end else begin
        pc_nx    = br_tgt;
        state_nx = RUN;
      end
    end else begin
      case (state)
        BOOT: state_nx = RUN;
        RUN: begin
          if (inst_req && inst_ack) begin
            if_valid_nx = 1'b1;
            if_pc_nx    = pc;
            pc_nx       = pc + 64'd4;
          end else if (inst_req) begin
            state_nx = WAIT;
          end
        end
        WAIT: begin
          if (inst_ack) begin
            pc_nx = pc + 64'd4;
            if (!stall) begin
              if_valid_nx = 1'b1;
              if_pc_nx    = pc;
              state_nx    = RUN;
            end else begin
              buf_pc_nx = pc;
              state_nx  = FULL;
            end
          end
        end
        FULL: begin
          if (!stall) begin
            if_valid_nx = 1'b1;
            if_pc_nx    = buf_pc;
            state_nx    = RUN;
          end
        end
        KILL: begin
          if (inst_ack) begin
            pc_nx    = tgt_pc;
            state_nx = RUN;
          end
        end
        default: state_nx = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      buf_pc   <= 64'd0;
      tgt_pc   <= 64'd0;
      if_valid <= 1'b0;
      if_pc    <= 64'd0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      buf_pc   <= buf_pc_nx;
      tgt_pc   <= tgt_pc_nx;
      if_valid <= if_valid_nx;
      if_pc    <= if_pc_nx;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - randomized self-checking bench for pc_gen against a fetch-level model.
module tb_pc_gen;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall = 1'b0;
  logic        br_e = 1'b0;
  logic [63:0] br_addr = 64'd0;
  logic        inst_req;
  logic [63:0] inst_addr;
  logic        inst_ack = 1'b0;
  logic        if_valid;
  logic [63:0] if_pc;
  logic        flush;
  logic        misalign_err;

  int tests = 0;
  int fails = 0;

  pc_gen #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .resetn(resetn), .stall(stall), .br_e(br_e), .br_addr(br_addr),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack),
    .if_valid(if_valid), .if_pc(if_pc), .flush(flush), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Fetch-level model: an outstanding request, an optional dropped response, one held instruction.
  bit          m_boot, m_out, m_drop, m_held, m_valid, m_err;
  logic [63:0] m_pc, m_tgt, m_buf, m_ifpc;

  always @(negedge clk) begin
    if (!resetn) begin
      m_boot = 1; m_out = 0; m_drop = 0; m_held = 0; m_valid = 0; m_err = 0;
      m_pc = RST_PC; m_tgt = 0; m_buf = 0; m_ifpc = 0;
      check("rst_req", inst_req, 0);
      check("rst_addr", inst_addr, RST_PC);
      check("rst_valid", if_valid, 0);
      check("rst_ifpc", if_pc, 0);
      check("rst_flush", flush, 0);
      check("rst_err", misalign_err, 0);
    end else begin
      bit          take, e_req;
      logic [63:0] target;
`ifdef PC_ALIGN_CHK_EN
      take   = br_e && (br_addr[1:0] == 2'b00);
      target = br_addr;
`else
      take   = br_e;
      target = br_addr & ~64'h3;
`endif
      e_req = !m_boot && !m_held && (m_out || !stall);
      check("req", inst_req, e_req);
      if (e_req) check("addr", inst_addr, m_pc);
      check("flush", flush, take);
      check("valid", if_valid, m_valid);
      if (m_valid) check("ifpc", if_pc, m_ifpc);
      check("err", misalign_err, m_err);

      if (br_e && !take) m_err = 1;
      if (take) begin
        m_valid = 0; m_held = 0; m_boot = 0;
        if (e_req && !inst_ack) begin
          m_out = 1; m_drop = 1; m_tgt = target;
        end else begin
          m_pc = target; m_out = 0; m_drop = 0;
        end
      end else if (m_boot) begin
        m_boot = 0;
      end else if (e_req && inst_ack) begin
        if (m_drop) begin
          m_pc = m_tgt; m_drop = 0;
          if (!stall) m_valid = 0;
        end else if (!stall) begin
          m_valid = 1; m_ifpc = m_pc; m_pc = m_pc + 64'd4;
        end else begin
          m_held = 1; m_buf = m_pc; m_pc = m_pc + 64'd4;
        end
        m_out = 0;
      end else begin
        if (e_req) m_out = 1;
        if (m_held && !stall) begin
          m_valid = 1; m_ifpc = m_buf; m_held = 0;
        end else if (!stall) begin
          m_valid = 0;
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic s, input logic a, input logic b, input logic [63:0] ba);
    @(posedge clk);
    #1;
    resetn = r; stall = s; inst_ack = a; br_e = b; br_addr = ba;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) cyc(0, 0, 0, 0, 0);
    check("lit_rst_addr", inst_addr, 64'h8000_0000);
    cyc(1, 0, 1, 0, 0);
    check("lit_boot_req", inst_req, 0);
    cyc(1, 0, 1, 0, 0);
    check("lit_req0", inst_addr, 64'h8000_0000);
    cyc(1, 0, 1, 0, 0);
    check("lit_req1", inst_addr, 64'h8000_0004);
    check("lit_ifpc0", if_pc, 64'h8000_0000);
    cyc(1, 0, 1, 0, 0);
    check("lit_req2", inst_addr, 64'h8000_0008);
    check("lit_ifpc1", if_pc, 64'h8000_0004);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("lit_wait_hold_a", inst_addr, 64'h8000_000C);
    cyc(1, 0, 0, 0, 0);
    check("lit_wait_hold_b", inst_addr, 64'h8000_000C);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("lit_wait_deliv", if_pc, 64'h8000_000C);
    check("lit_wait_pc4", inst_addr, 64'h8000_0010);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("lit_full_req", inst_req, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("lit_full_ifpc", if_pc, 64'h8000_0010);
    check("lit_full_valid", if_valid, 1);
    check("lit_full_next", inst_addr, 64'h8000_0014);
    cyc(1, 0, 0, 1, 64'h8000_0100);
    check("lit_kill_flush", flush, 1);
    cyc(1, 1, 0, 0, 0);
    check("lit_kill_hold", inst_addr, 64'h8000_0014);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    check("lit_kill_tgt", inst_addr, 64'h8000_0100);
    check("lit_kill_drop", if_valid, 0);
    cyc(1, 0, 1, 1, 64'h8000_0102);
    cyc(1, 0, 1, 0, 0);
`ifdef PC_ALIGN_CHK_EN
    check("lit_mis_err", misalign_err, 1);
    check("lit_mis_next", inst_addr, 64'h8000_0108);
`else
    check("lit_mis_err", misalign_err, 0);
    check("lit_mis_next", inst_addr, 64'h8000_0100);
`endif
    cyc(1, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(1, 0, 1, 0, 0);
    check("lit_wrap_a", inst_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(1, 0, 0, 0, 0);
    check("lit_wrap_b", inst_addr, 64'h0);
    cyc(1, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("lit_midrst_req", inst_req, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    check("lit_after_rst", inst_addr, 64'h8000_0000);

    for (int i = 0; i < 4000; i++) begin
      logic [63:0] ba;
      logic        r;
      ba = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: ba[1:0] = 2'b00;
        1: ba = 64'hFFFF_FFFF_FFFF_FFF0 | {60'd0, ba[3:0]};
        default: ;
      endcase
      r = ($urandom_range(0, 199) != 0);
      cyc(r, $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
          $urandom_range(0, 9) == 0, ba);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000: first fetch address after reset.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 stall  in  1  decode stage cannot accept a new instruction this cycle.
REQ-005 br_e  in  1  redirect request from the execute-stage branch unit.
REQ-006 br_addr  in  64  redirect target, valid when br_e=1.
REQ-007 inst_req  out  1  fetch request to instruction memory.
REQ-008 inst_addr  out  64  fetch address, valid when inst_req=1.
REQ-009 inst_ack  in  1  memory accepted the request and returned the instruction this cycle; meaningful only when inst_req=1.
REQ-010 if_valid  out  1  if_pc holds a live instruction for decode.
REQ-011 if_pc  out  64  PC of the instruction presented to decode.
REQ-012 flush  out  1  kill wrong-path instructions in the IF/ID stages.
REQ-013 misalign_err  out  1  sticky misaligned-redirect flag (see REQ-031).

Function
REQ-014 The FSM SHALL have states BOOT, RUN, WAIT, FULL and KILL; registers pc, buf_pc, tgt_pc.
REQ-015 BOOT: inst_req=0 for exactly one cycle after reset release, then RUN.
REQ-016 RUN: inst_req=~stall, inst_addr=pc; on req&ack, if_pc<=pc, if_valid<=1, pc<=pc+4, stay in RUN; on req&~ack, go to WAIT.
REQ-017 WAIT: inst_req=1, inst_addr=pc. On ack&~stall, deliver as in REQ-016 and go to RUN. On ack&stall, buf_pc<=pc, pc<=pc+4, go to FULL. With no ack, stay in WAIT.
REQ-018 FULL: inst_req=0. When ~stall: if_pc<=buf_pc, if_valid<=1, go to RUN.
REQ-019 Once inst_req=1 without ack, inst_req and inst_addr SHALL stay stable until ack, regardless of stall or br_e.
REQ-020 When stall=1 and nothing is delivered, if_valid and if_pc SHALL hold. When stall=0 and nothing is delivered, if_valid<=0.
REQ-021 br_e has the highest priority: flush=br_e combinationally in the same cycle; if_valid<=0 at the next edge; the FULL buffer is discarded; any ack in that cycle is discarded.
REQ-022 If br_e arrives in WAIT or KILL without an ack, tgt_pc<=br_addr and go to KILL. Otherwise pc<=br_addr and go to RUN.
REQ-023 KILL: inst_req=1, inst_addr=old pc. On ack, discard the response, pc<=tgt_pc, go to RUN. If br_e arrives again in KILL, tgt_pc is overwritten (latest wins).
REQ-024 br_e overrides stall; with br_e=1 and stall=1, the redirect still takes effect.
REQ-025 PC arithmetic SHALL be 64-bit modulo 2^64; pc=64'hFFFF_FFFF_FFFF_FFFC advances to 0 with no flag.
REQ-026 Fetch latency: a request acked in cycle N yields if_valid=1, if_pc=address at edge N+1.

Reset
REQ-027 While resetn=0: state=BOOT, pc=RESET_PC, inst_req=0, inst_addr=RESET_PC, if_valid=0, if_pc=0, flush=0, misalign_err=0, buf_pc=tgt_pc=0.
REQ-028 Reset asserted mid-WAIT or mid-KILL SHALL abandon the outstanding request immediately; no ack is consumed afterwards.
REQ-029 The first request after reset SHALL be inst_addr=RESET_PC in the cycle after BOOT.

Configuration
REQ-030 Macro PC_ALIGN_CHK_EN.
REQ-031 Defined: br_e with br_addr[1:0]!=0 is ignored (no flush, no redirect) and sets misalign_err=1 at the next edge; it stays set until reset.
REQ-032 Undefined: misalign_err is tied to 0, and the redirect uses {br_addr[63:2],2'b00}.

Verification
REQ-033 Reset release, ack always 1, stall=0 -> requests 8000_0000, 8000_0004, 8000_0008 on consecutive cycles; if_pc follows one cycle later.
REQ-034 ack held 0 for 3 cycles in WAIT with stall toggling -> inst_addr constant; one delivery on ack; pc+4 exactly once.
REQ-035 ack with stall=1 in WAIT (pc=8000_0010) -> FULL, inst_req=0; stall drop -> if_pc=8000_0010, if_valid=1, next request 8000_0014.
REQ-036 br_e, br_addr=8000_0100 in WAIT without ack -> flush=1 that cycle, KILL; old address held until ack; response dropped; next request 8000_0100.
REQ-037 br_e, br_addr=8000_0102, PC_ALIGN_CHK_EN defined -> no flush, misalign_err=1 sticky; without the macro -> redirect to 8000_0100.
REQ-038 pc=FFFF_FFFF_FFFF_FFFC acked -> next inst_addr=0.
